// File: rtl/eq3_autosolver.sv
// eq3_autosolver: solves a 2x2 linear system with Cramer's rule and sends x, y to a receiver.
// Optional feature macro: EQ3_AUTOSOLVE_VERIFY_EN (wait for the receiver's 'correct' after sending y).
module eq3_autosolver #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       start,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic [7:0] c1,
    input  logic [7:0] a2,
    input  logic [7:0] b2,
    input  logic [7:0] c2,
    input  logic       correct,
    output logic       Go,
    output logic [7:0] DataIn,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned DW        = 8;
    localparam int unsigned PW        = 16;
    localparam int unsigned NW        = 17;
    localparam int unsigned CW        = 16;
    localparam int unsigned DIV_STEPS = 16;

    typedef enum logic [3:0] {
        S_IDLE, S_CALC, S_DIVX, S_DIVY, S_SEND_X, S_GAP_X,
        S_SEND_Y, S_GAP_Y, S_WAIT_ACK, S_DONE, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] a1_q, b1_q, c1_q, a2_q, b2_q, c2_q;
    logic [DW-1:0] a1_d, b1_d, c1_d, a2_d, b2_d, c2_d;
    logic [PW-1:0] dsr_q, dsr_d;
    logic [PW-1:0] numy_q, numy_d;
    logic [PW-1:0] div_q, div_d;
    logic [PW-1:0] rem_q, rem_d;
    logic [DW-1:0] x_q, x_d, y_q, y_d;
    logic          go_q, go_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [DW-1:0] data_q, data_d;

    logic [PW-1:0] p_a1b2_c, p_a2b1_c, p_c1b2_c, p_c2b1_c, p_a1c2_c, p_a2c1_c;
    logic [NW-1:0] det_c, nx_c, ny_c;
    logic [PW-1:0] det_abs_c, nx_abs_c, ny_abs_c;
    logic          bad_sign_c;
    logic [NW-1:0] shifted_c;
    logic          ge_c;
    logic [PW-1:0] rem_n_c, quot_c;

`ifndef EQ3_AUTOSOLVE_VERIFY_EN
    logic [16:0] unused_verify;
    assign unused_verify = {correct, 16'(ACK_TIMEOUT)};
`endif

    // Cramer determinants (two's complement, 17 bits) and their magnitudes
    always_comb begin
        p_a1b2_c   = 16'(a1_q) * 16'(b2_q);
        p_a2b1_c   = 16'(a2_q) * 16'(b1_q);
        p_c1b2_c   = 16'(c1_q) * 16'(b2_q);
        p_c2b1_c   = 16'(c2_q) * 16'(b1_q);
        p_a1c2_c   = 16'(a1_q) * 16'(c2_q);
        p_a2c1_c   = 16'(a2_q) * 16'(c1_q);
        det_c      = {1'b0, p_a1b2_c} - {1'b0, p_a2b1_c};
        nx_c       = {1'b0, p_c1b2_c} - {1'b0, p_c2b1_c};
        ny_c       = {1'b0, p_a1c2_c} - {1'b0, p_a2c1_c};
        det_abs_c  = det_c[16] ? 16'(-det_c) : det_c[15:0];
        nx_abs_c   = nx_c[16]  ? 16'(-nx_c)  : nx_c[15:0];
        ny_abs_c   = ny_c[16]  ? 16'(-ny_c)  : ny_c[15:0];
        bad_sign_c = ((nx_c != '0) && (nx_c[16] != det_c[16])) ||
                     ((ny_c != '0) && (ny_c[16] != det_c[16]));
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        shifted_c = {rem_q, div_q[PW-1]};
        ge_c      = shifted_c >= {1'b0, dsr_q};
        rem_n_c   = ge_c ? 16'(shifted_c - {1'b0, dsr_q}) : shifted_c[15:0];
        quot_c    = {div_q[PW-2:0], ge_c};
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a1_d = a1_q; b1_d = b1_q; c1_d = c1_q;
        a2_d = a2_q; b2_d = b2_q; c2_d = c2_q;
        dsr_d   = dsr_q;
        numy_d  = numy_q;
        div_d   = div_q;
        rem_d   = rem_q;
        x_d     = x_q;
        y_d     = y_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a1_d = a1; b1_d = b1; c1_d = c1;
                    a2_d = a2; b2_d = b2; c2_d = c2;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                cnt_d = '0;
                if ((det_c == '0) || bad_sign_c) begin
                    state_d = S_ERR;
                end else begin
                    dsr_d   = det_abs_c;
                    div_d   = nx_abs_c;
                    numy_d  = ny_abs_c;
                    rem_d   = '0;
                    state_d = S_DIVX;
                end
            end
            S_DIVX, S_DIVY: begin
                div_d = quot_c;
                rem_d = rem_n_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DIV_STEPS - 1)) begin
                    cnt_d = '0;
                    if ((rem_n_c != '0) || (quot_c[15:8] != 8'd0)) begin
                        state_d = S_ERR;
                    end else if (state_q == S_DIVX) begin
                        x_d     = quot_c[7:0];
                        div_d   = numy_q;
                        rem_d   = '0;
                        state_d = S_DIVY;
                    end else begin
                        y_d     = quot_c[7:0];
                        state_d = S_SEND_X;
                    end
                end
            end
            S_SEND_X, S_SEND_Y: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_SEND_X) ? S_GAP_X : S_GAP_Y;
                end
            end
            S_GAP_X: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SEND_Y;
                end
            end
            S_GAP_Y: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
`ifdef EQ3_AUTOSOLVE_VERIFY_EN
                    state_d = S_WAIT_ACK;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_WAIT_ACK: begin
`ifdef EQ3_AUTOSOLVE_VERIFY_EN
                cnt_d = cnt_q + CW'(1);
                if (correct) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    state_d = S_ERR;
                end
`else
                cnt_d   = '0;
                state_d = S_IDLE;
`endif
            end
            S_DONE, S_ERR: begin
                if (!start) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Outputs follow the current state one cycle later, through registers
        go_d   = (state_q == S_SEND_X) || (state_q == S_SEND_Y);
        data_d = '0;
        if ((state_q == S_SEND_X) || (state_q == S_GAP_X)) data_d = x_q;
        if ((state_q == S_SEND_Y) || (state_q == S_GAP_Y)) data_d = y_q;
        busy_d = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
        done_d = (state_q == S_DONE);
        err_d  = (state_q == S_ERR);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a1_q <= '0; b1_q <= '0; c1_q <= '0;
            a2_q <= '0; b2_q <= '0; c2_q <= '0;
            dsr_q   <= '0;
            numy_q  <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            go_q    <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a1_q <= a1_d; b1_q <= b1_d; c1_q <= c1_d;
            a2_q <= a2_d; b2_q <= b2_d; c2_q <= c2_d;
            dsr_q   <= dsr_d;
            numy_q  <= numy_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            x_q     <= x_d;
            y_q     <= y_d;
            go_q    <= go_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign Go     = go_q;
    assign DataIn = data_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = err_q;

endmodule

// File: tb/tb_eq3_autosolver.sv
// Bench for eq3_autosolver: directed table, hand sequences and random solves vs. an integer model.
module tb_eq3_autosolver;

    localparam int H       = 4;
    localparam int G       = 4;
    localparam int T_GO    = 34;
    localparam int T_DONE  = T_GO + 2 * H + 2 * G;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a1 = '0, b1 = '0, c1 = '0, a2 = '0, b2 = '0, c2 = '0;
    logic       correct = 1'b0;
    logic       Go;
    logic [7:0] DataIn;
    logic       busy, done, error;

    int vectors    = 0;
    int miscompares = 0;

    eq3_autosolver #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .ACK_TIMEOUT(64)) dut (
        .Clock(Clock), .Reset(Reset), .start(start),
        .a1(a1), .b1(b1), .c1(c1), .a2(a2), .b2(b2), .c2(c2),
        .correct(correct), .Go(Go), .DataIn(DataIn),
        .busy(busy), .done(done), .error(error)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int a1, b1, c1, a2, b2, c2;
        bit ok;
        int x, y, terr;
    } vec_t;

    // Integer reference: Cramer's rule on exact integers, error cycle from where it is detected
    function automatic void model(input int ia1, ib1, ic1, ia2, ib2, ic2,
                                  output bit ok, output int x, output int y, output int terr);
        int det, nx, ny;
        det = ia1 * ib2 - ia2 * ib1;
        nx  = ic1 * ib2 - ic2 * ib1;
        ny  = ia1 * ic2 - ia2 * ic1;
        ok = 1'b0; x = 0; y = 0; terr = 0;
        if (det == 0) terr = 2;
        else if ((nx != 0 && ((nx < 0) != (det < 0))) || (ny != 0 && ((ny < 0) != (det < 0)))) terr = 2;
        else if ((nx % det) != 0 || (nx / det) > 255) terr = 18;
        else if ((ny % det) != 0 || (ny / det) > 255) terr = 34;
        else begin
            ok = 1'b1; x = nx / det; y = ny / det;
        end
    endfunction

    // Expected {Go, DataIn, busy, done, error} k cycles after the start-sampling edge
    function automatic logic [11:0] expect_at(input int k, input bit ok, input int x, input int y, input int terr);
        logic g, bs, dn, er;
        logic [7:0] d;
        g = 0; bs = 0; dn = 0; er = 0; d = '0;
        if (ok) begin
            bs = (k >= 1) && (k <= T_DONE - 1);
            dn = (k == T_DONE);
            g  = ((k >= T_GO) && (k < T_GO + H)) || ((k >= T_GO + H + G) && (k < T_GO + 2 * H + G));
            if ((k >= T_GO) && (k < T_GO + H + G)) d = 8'(x);
            if ((k >= T_GO + H + G) && (k < T_DONE)) d = 8'(y);
        end else begin
            bs = (k >= 1) && (k <= terr - 1);
            er = (k == terr);
        end
        return {g, d, bs, dn, er};
    endfunction

    task automatic check(input string nm, input int k, input logic [11:0] exp);
        logic [11:0] got;
        got = {Go, DataIn, busy, done, error};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s k=%0d got go=%b data=%0d busy=%b done=%b err=%b, want go=%b data=%0d busy=%b done=%b err=%b",
                     nm, k, got[11], got[10:3], got[2], got[1], got[0],
                     exp[11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Pulse start with the given coefficients, scramble coefficients afterwards, check every cycle
    task automatic run_solve(input string nm, input vec_t v, input int abort_at);
        int last;
        last = v.ok ? T_DONE + 2 : v.terr + 2;
        a1 = 8'(v.a1); b1 = 8'(v.b1); c1 = 8'(v.c1);
        a2 = 8'(v.a2); b2 = 8'(v.b2); c2 = 8'(v.c2);
        start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        for (int k = 1; k <= last; k++) begin
            a1 = 8'($urandom); b1 = 8'($urandom); c1 = 8'($urandom);
            a2 = 8'($urandom); b2 = 8'($urandom); c2 = 8'($urandom);
            @(posedge Clock); #1;
            check(nm, k, expect_at(k, v.ok, v.x, v.y, v.terr));
            if (k == abort_at) begin
                Reset = 1'b1;
                @(posedge Clock); #1;
                check({nm, "_reset"}, k + 1, 12'h000);
                Reset = 1'b0;
                return;
            end
        end
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        tbl[0] = '{2, 1, 5, 1, 1, 3,       1'b1, 2,   1,   0};
        tbl[1] = '{2, 4, 6, 1, 2, 3,       1'b0, 0,   0,   2};
        tbl[2] = '{1, 1, 3, 2, 2, 5,       1'b0, 0,   0,   2};
        tbl[3] = '{2, 0, 3, 0, 1, 1,       1'b0, 0,   0,   18};
        tbl[4] = '{1, 0, 4, 0, 2, 3,       1'b0, 0,   0,   34};
        tbl[5] = '{1, 1, 1, 1, 2, 5,       1'b0, 0,   0,   2};
        tbl[6] = '{1, 2, 8, 2, 1, 7,       1'b1, 2,   3,   0};
        tbl[7] = '{1, 1, 255, 2, 1, 255,   1'b1, 0,   255, 0};
        tbl[8] = '{255, 0, 255, 0, 255, 255, 1'b1, 1, 1,   0};

        // Reset state
        repeat (3) @(posedge Clock);
        #1;
        check("reset_state", 0, 12'h000);
        Reset = 1'b0;
        @(posedge Clock); #1;
        check("idle_after_reset", 0, 12'h000);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_solve($sformatf("table%0d", i), tbl[i], 0);
            repeat (2) @(posedge Clock);
            #1;
        end

        // Reset during the 2nd Go-high cycle of x, then a fresh solve
        run_solve("abort_send_x", tbl[0], T_GO + 1);
        @(posedge Clock); #1;
        check("idle_after_abort", 0, 12'h000);
        run_solve("after_abort", tbl[6], 0);

        // Reset has priority over start
        Reset = 1'b1; start = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check("reset_over_start", 0, 12'h000);
        Reset = 1'b0; start = 1'b0;
        @(posedge Clock); #1;

        // start held high: DONE holds, no retrigger, then returns to idle
        a1 = 8'd2; b1 = 8'd1; c1 = 8'd5; a2 = 8'd1; b2 = 8'd1; c2 = 8'd3;
        start = 1'b1;
        repeat (T_DONE + 1) @(posedge Clock);
        #1;
        check("done_held", T_DONE, 12'h002);
        repeat (8) @(posedge Clock);
        #1;
        check("done_no_retrigger", T_DONE + 8, 12'h002);
        start = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("done_release", 0, 12'h000);
        repeat (3) @(posedge Clock);
        #1;
        check("idle_stays", 0, 12'h000);

        // Random solves against the integer model
        for (int i = 0; i < 36; i++) begin
            int xs, ys;
            case (i % 3)
                0: begin
                    rv.a1 = $urandom_range(1, 15); rv.b1 = $urandom_range(0, 15);
                    rv.a2 = $urandom_range(0, 15); rv.b2 = $urandom_range(1, 15);
                    xs = $urandom_range(0, 7); ys = $urandom_range(0, 7);
                    rv.c1 = rv.a1 * xs + rv.b1 * ys;
                    rv.c2 = rv.a2 * xs + rv.b2 * ys;
                end
                1: begin
                    rv.a1 = $urandom_range(0, 3); rv.b1 = $urandom_range(0, 3); rv.c1 = $urandom_range(0, 7);
                    rv.a2 = $urandom_range(0, 3); rv.b2 = $urandom_range(0, 3); rv.c2 = $urandom_range(0, 7);
                end
                default: begin
                    rv.a1 = $urandom_range(0, 255); rv.b1 = $urandom_range(0, 255); rv.c1 = $urandom_range(0, 255);
                    rv.a2 = $urandom_range(0, 255); rv.b2 = $urandom_range(0, 255); rv.c2 = $urandom_range(0, 255);
                end
            endcase
            model(rv.a1, rv.b1, rv.c1, rv.a2, rv.b2, rv.c2, rv.ok, rv.x, rv.y, rv.terr);
            run_solve($sformatf("rand%0d", i), rv, 0);
            @(posedge Clock); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
